// File: rtl/l2c_cout_nch.sv
// l2c_cout_nch: N-channel L2C response arbiter feeding a registered output FIFO.
// Round-robin or fixed-priority grant; downstream back-pressure via out_ack/full.
module l2c_cout_nch #(
  parameter int NCH    = 4,
  parameter int UID_W  = 8,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  prio_mode,
  input  logic [NCH-1:0]        req,
  input  logic [NCH*UID_W-1:0]  req_uid,
  input  logic [NCH*DATA_W-1:0] req_data,
  output logic [NCH-1:0]        ack,
  output logic                  out_rdy,
  output logic [UID_W-1:0]      out_uid,
  output logic [DATA_W-1:0]     out_data,
  input  logic                  out_ack,
  output logic                  full
);

  localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [PW-1:0]     ptr_q, ptr_d;
  logic [AW-1:0]     wr_q, wr_d;
  logic [AW-1:0]     rd_q, rd_d;
  logic [CW-1:0]     count_q, count_d;
  logic              full_q, full_d;
  logic [UID_W-1:0]  uid_mem_q [DEPTH];
  logic [UID_W-1:0]  uid_mem_d [DEPTH];
  logic [DATA_W-1:0] data_mem_q [DEPTH];
  logic [DATA_W-1:0] data_mem_d [DEPTH];

  logic          found;
  logic [PW-1:0] win;
  logic          push;
  logic          pop;

  // Search starts at ptr in round-robin mode, at channel 0 in fixed mode.
  always_comb begin
    int            idx;
    logic [PW-1:0] idx_p;
    found = 1'b0;
    win   = '0;
    for (int i = 0; i < NCH; i++) begin
      idx = prio_mode ? i : int'(ptr_q) + i;
      if (idx >= NCH) idx = idx - NCH;
      idx_p = PW'(idx);
      if (!found && req[idx_p]) begin
        found = 1'b1;
        win   = idx_p;
      end
    end
  end

  always_comb begin
    ack = '0;
    if (found && !rst && !full_q) ack = NCH'(1) << win;
  end

  assign push = |ack;
  assign pop  = out_ack && (count_q != '0);

  always_comb begin
    ptr_d      = ptr_q;
    wr_d       = wr_q;
    rd_d       = rd_q;
    uid_mem_d  = uid_mem_q;
    data_mem_d = data_mem_q;
    if (push && !prio_mode) begin
      ptr_d = (win == PW'(NCH - 1)) ? '0 : win + 1'b1;
    end
    if (push) begin
      uid_mem_d[wr_q]  = req_uid[int'(win)*UID_W +: UID_W];
      data_mem_d[wr_q] = req_data[int'(win)*DATA_W +: DATA_W];
      wr_d             = wr_q + 1'b1;
    end
    if (pop) rd_d = rd_q + 1'b1;
    count_d = count_q + CW'(push) - CW'(pop);
    full_d  = (count_d == CW'(DEPTH));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q   <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
      full_q  <= full_d;
    end
  end

  // Storage needs no reset: count gates every read of it.
  always_ff @(posedge clk) begin
    uid_mem_q  <= uid_mem_d;
    data_mem_q <= data_mem_d;
  end

  assign out_rdy  = (count_q != '0);
  assign out_uid  = out_rdy ? uid_mem_q[rd_q] : '0;
  assign out_data = out_rdy ? data_mem_q[rd_q] : '0;
  assign full     = full_q;

endmodule

// File: tb/tb_l2c_cout_nch.sv
// Directed bench for l2c_cout_nch (NCH=4, DEPTH=4).
module tb_l2c_cout_nch;

  localparam int NCH = 4;
  localparam int UW  = 8;
  localparam int DW  = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            prio_mode;
  logic [NCH-1:0]  req;
  logic [NCH*UW-1:0] req_uid;
  logic [NCH*DW-1:0] req_data;
  logic [NCH-1:0]  ack;
  logic            out_rdy;
  logic [UW-1:0]   out_uid;
  logic [DW-1:0]   out_data;
  logic            out_ack;
  logic            full;

  int checks = 0;
  int errors = 0;

  l2c_cout_nch #(.NCH(NCH), .UID_W(UW), .DATA_W(DW), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .prio_mode(prio_mode),
    .req(req), .req_uid(req_uid), .req_data(req_data),
    .ack(ack), .out_rdy(out_rdy), .out_uid(out_uid),
    .out_data(out_data), .out_ack(out_ack), .full(full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_uid0(input logic [7:0] u);
    req_uid[7:0]   = u;
    req_data[31:0] = {24'hD00000, u};
  endtask

  logic [3:0] rr_ack [5];
  logic [7:0] rr_uid [5];

  initial begin
    rr_ack[0] = 4'b0001; rr_ack[1] = 4'b0010; rr_ack[2] = 4'b0100;
    rr_ack[3] = 4'b1000; rr_ack[4] = 4'b0001;
    rr_uid[0] = 8'h00; rr_uid[1] = 8'hA0; rr_uid[2] = 8'hA1;
    rr_uid[3] = 8'hA2; rr_uid[4] = 8'hA3;

    rst = 1'b1; prio_mode = 1'b0; req = 4'b1111; out_ack = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      req_uid[k*UW +: UW]  = 8'hA0 + 8'(k);
      req_data[k*DW +: DW] = 32'hD000_00A0 + k;
    end

    // reset: two cycles with all requests up
    tick();
    chk("rst_ack", 32'(ack), 32'h0);
    chk("rst_rdy", 32'(out_rdy), 32'h0);
    chk("rst_full", 32'(full), 32'h0);
    tick();
    chk("rst_ack2", 32'(ack), 32'h0);
    chk("rst_uid", 32'(out_uid), 32'h0);
    chk("rst_data", out_data, 32'h0);

    // round-robin rotation with consumer always ready
    rst = 1'b0; out_ack = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("rr_ack", 32'(ack), 32'(rr_ack[i]));
      if (i > 0) chk("rr_uid", 32'(out_uid), 32'(rr_uid[i]));
      tick();
    end
    chk("rr_data3", out_data, 32'hD000_00A0);
    req = 4'b0000;
    #1;
    chk("rr_tail", 32'(out_uid), 32'hA0);
    tick();
    chk("rr_empty", 32'(out_rdy), 32'h0);
    chk("rr_empty_uid", 32'(out_uid), 32'h0);

    // fixed priority: ch1 always wins over ch2, ptr stays at 1
    prio_mode = 1'b1; req = 4'b0110;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("fix_ack", 32'(ack), 32'h2);
      if (i > 0) chk("fix_uid", 32'(out_uid), 32'hA1);
      tick();
    end
    prio_mode = 1'b0; req = 4'b1111;
    #1;
    chk("fix_ptr", 32'(ack), 32'h2);
    req = 4'b0000;
    #1;
    tick();
    chk("fix_drain", 32'(out_rdy), 32'h0);

    // fill to full, then one pop lets exactly one more beat in
    out_ack = 1'b0; req = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      set_uid0(8'h10 + 8'(i));
      #1;
      chk("fill_ack", 32'(ack), 32'h1);
      chk("fill_full", 32'(full), 32'h0);
      tick();
    end
    set_uid0(8'h14);
    #1;
    chk("full_set", 32'(full), 32'h1);
    chk("full_ack", 32'(ack), 32'h0);
    chk("full_head", 32'(out_uid), 32'h10);
    out_ack = 1'b1;
    tick();
    out_ack = 1'b0;
    #1;
    chk("full_drop", 32'(full), 32'h0);
    chk("full_ack1", 32'(ack), 32'h1);
    tick();
    chk("full_again", 32'(full), 32'h1);
    chk("full_ack0", 32'(ack), 32'h0);
    req = 4'b0000; out_ack = 1'b1;
    for (int i = 1; i < 5; i++) begin
      #1;
      chk("full_order", 32'(out_uid), 32'(8'h10 + 8'(i)));
      tick();
    end
    chk("full_empty", 32'(out_rdy), 32'h0);

    // hold count at 2 with push+pop every cycle
    out_ack = 1'b0; req = 4'b0001;
    set_uid0(8'h20); tick();
    set_uid0(8'h21); tick();
    out_ack = 1'b1;
    for (int i = 0; i < 5; i++) begin
      set_uid0(8'h22 + 8'(i));
      #1;
      chk("pp_ack", 32'(ack), 32'h1);
      chk("pp_uid", 32'(out_uid), 32'(8'h20 + 8'(i)));
      chk("pp_data", out_data, 32'hD000_0020 + i);
      tick();
    end
    req = 4'b0000;
    #1;
    chk("pp_head5", 32'(out_uid), 32'h25);
    tick();
    chk("pp_head6", 32'(out_uid), 32'h26);
    tick();
    chk("pp_empty", 32'(out_rdy), 32'h0);

    // reset mid-stream discards buffered beats
    out_ack = 1'b0; req = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      set_uid0(8'h30 + 8'(i));
      tick();
    end
    chk("mid_rdy", 32'(out_rdy), 32'h1);
    set_uid0(8'h33);
    rst = 1'b1;
    #1;
    chk("mid_rst_ack", 32'(ack), 32'h0);
    tick();
    rst = 1'b0;
    chk("mid_rdy0", 32'(out_rdy), 32'h0);
    chk("mid_uid0", 32'(out_uid), 32'h0);
    set_uid0(8'h40);
    #1;
    chk("mid_ack", 32'(ack), 32'h1);
    tick();
    req = 4'b0000; out_ack = 1'b1;
    #1;
    chk("mid_uid", 32'(out_uid), 32'h40);
    tick();
    chk("mid_only", 32'(out_rdy), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
